// File: rtl/serial_booth_mult_engine.sv
// rtl/serial_booth_mult_engine.sv - serial-load, serial-unload radix-2 Booth signed multiplier
//
// Operands A and B shift in LSB-first, an iterative Booth datapath forms the
// 2*WIDTH-bit signed product, and the product shifts out on two lanes
// (low half / high half) while also being held on a parallel port.
//
// Ports:
//   wb_clk_i     clock
//   wb_rst_i     synchronous active-high reset; aborts any operation
//   start_i      request, sampled only in IDLE
//   approx_i     mode, latched with start_i (1 = clear APPROX_BITS LSBs of A)
//   a_ser_i      serial A bit, LSB first
//   b_ser_i      serial B bit, LSB first
//   busy_o       high in every state except IDLE
//   out_lo_o     serial product bit k
//   out_hi_o     serial product bit WIDTH+k
//   out_valid_o  lanes carry valid bits
//   done_o       one-cycle pulse after the last output bit
//   result_o     parallel product, held until the next multiply completes
module serial_booth_mult_engine #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic               approx_i,
  input  logic               a_ser_i,
  input  logic               b_ser_i,
  output logic               busy_o,
  output logic               out_lo_o,
  output logic               out_hi_o,
  output logic               out_valid_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] APPROX_MASK = ~WIDTH'((64'd1 << APPROX_BITS) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic               prev_q, prev_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               out_lo_q, out_lo_d;
  logic               out_hi_q, out_hi_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;

  // Booth step datapath: B itself is the low half of the shifting product
  // register, so after WIDTH steps {acc, b} holds the full product.
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     mcand_x;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   result_lo;
  logic [WIDTH-1:0]   result_hi;

  assign result_lo = result_q[WIDTH-1:0];
  assign result_hi = result_q[2*WIDTH-1:WIDTH];

  always_comb begin
    mcand   = mode_q ? (a_q & APPROX_MASK) : a_q;
    mcand_x = {mcand[WIDTH-1], mcand};
    case ({b_q[0], prev_q})
      2'b01:   sum = acc_q + mcand_x;
      2'b10:   sum = acc_q - mcand_x;
      default: sum = acc_q;
    endcase
    acc_sh = {sum[WIDTH], sum[WIDTH:1]};
    b_sh   = {sum[0], b_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    prev_d      = prev_q;
    result_d    = result_q;
    out_lo_d    = 1'b0;
    out_hi_d    = 1'b0;
    out_valid_d = 1'b0;
    // The cycle after the last valid bit has been presented: SHIFT has
    // already handed over to IDLE (or the next LOAD) while valid is still set.
    done_d      = out_valid_q && (state_q != S_SHIFT);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          mode_d  = approx_i;
        end
      end
      S_LOAD: begin
        a_d[cnt_q] = a_ser_i;
        b_d[cnt_q] = b_ser_i;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_COMP;
          cnt_d   = '0;
          acc_d   = '0;
          prev_d  = 1'b0;
        end
      end
      S_COMP: begin
        acc_d  = acc_sh;
        b_d    = b_sh;
        prev_d = b_q[0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d = {acc_sh[WIDTH-1:0], b_sh};
          state_d  = S_SHIFT;
          cnt_d    = '0;
        end
      end
      S_SHIFT: begin
        out_valid_d = 1'b1;
        out_lo_d    = result_lo[cnt_q];
        out_hi_d    = result_hi[cnt_q];
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      prev_q      <= 1'b0;
      result_q    <= '0;
      out_lo_q    <= 1'b0;
      out_hi_q    <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      prev_q      <= prev_d;
      result_q    <= result_d;
      out_lo_q    <= out_lo_d;
      out_hi_q    <= out_hi_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign out_lo_o    = out_lo_q;
  assign out_hi_o    = out_hi_q;
  assign out_valid_o = out_valid_q;
  assign done_o      = done_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_serial_booth_mult_engine.sv
// tb/tb_serial_booth_mult_engine.sv - self-checking bench for serial_booth_mult_engine
module tb_serial_booth_mult_engine;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        approx;
  logic        a_ser;
  logic        b_ser;
  logic        busy;
  logic        out_lo;
  logic        out_hi;
  logic        out_valid;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  serial_booth_mult_engine #(.WIDTH(W), .APPROX_BITS(4)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start_i    (start),
    .approx_i   (approx),
    .a_ser_i    (a_ser),
    .b_ser_i    (b_ser),
    .busy_o     (busy),
    .out_lo_o   (out_lo),
    .out_hi_o   (out_hi),
    .out_valid_o(out_valid),
    .done_o     (done),
    .result_o   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requests an operation, pushes the model product, then shifts the operands in.
  task automatic start_load(input logic [15:0] a, input logic [15:0] b, input logic ap);
    logic [15:0]        m;
    logic signed [15:0] sa;
    logic signed [15:0] sbv;
    logic signed [31:0] e;
    m   = ap ? (a & 16'hFFF0) : a;
    sa  = m;
    sbv = b;
    e   = sa * sbv;
    sb.push_back(e);
    start  = 1'b1;
    approx = ap;
    @(posedge clk);
    #1;
    start  = 1'b0;
    approx = 1'b0;
    check("busy_on_accept", {31'b0, busy}, 32'd1);
    for (int i = 0; i < W; i++) begin
      a_ser = a[i];
      b_ser = b[i];
      @(posedge clk);
      #1;
    end
    a_ser = 1'b0;
    b_ser = 1'b0;
  endtask

  // Collects the two serial lanes until done_o and checks against the scoreboard.
  // Cycle k counts edges after the accepting edge; p1/p2 pulse start_i mid-operation.
  task automatic collect(input string tag, input int p1, input int p2);
    logic [15:0] lo;
    logic [15:0] hi;
    logic [31:0] exp;
    int vcnt;
    int dk;
    int bad;
    lo = '0; hi = '0; vcnt = 0; dk = 0; bad = 0;
    for (int k = W + 1; k <= 120; k++) begin
      @(posedge clk);
      #1;
      start = (k == p1) || (k == p2);
      @(negedge clk);
      if (out_valid) begin
        if (vcnt < W) begin
          lo[vcnt] = out_lo;
          hi[vcnt] = out_hi;
        end
        vcnt++;
      end else if (out_lo || out_hi) begin
        bad++;
      end
      if (done) begin
        dk = k;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
    exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_done_cycle"}, dk, 32'd49);
    check({tag, "_result_o"}, result, exp);
    check({tag, "_serial"}, {hi, lo}, exp);
    check({tag, "_valid_window"}, vcnt, 32'd16);
    check({tag, "_idle_lanes_zero"}, bad, 32'd0);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) c++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; approx = 1'b0; a_ser = 1'b0; b_ser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_lanes", {30'b0, out_hi, out_lo}, 32'd0);
    check("reset_result", result, 32'd0);
    idle_cycles(1);

    // Basic exact product and latency
    start_load(16'd3, 16'd5, 1'b0);
    collect("t1", 0, 0);
    check("t1_const", result, 32'h0000_000F);
    idle_cycles(2);

    // Signed operands and the most-negative corner
    start_load(16'hFFFE, 16'd3, 1'b0);
    collect("t2a", 0, 0);
    check("t2a_const", result, 32'hFFFF_FFFA);
    idle_cycles(2);
    start_load(16'h8000, 16'h8000, 1'b0);
    collect("t2b", 0, 0);
    check("t2b_const", result, 32'h4000_0000);
    idle_cycles(2);

    // Approximate vs exact mode on the same operands
    start_load(16'h0013, 16'd2, 1'b1);
    collect("t3a", 0, 0);
    check("t3a_const", result, 32'h0000_0020);
    idle_cycles(2);
    start_load(16'h0013, 16'd2, 1'b0);
    collect("t3b", 0, 0);
    check("t3b_const", result, 32'h0000_0026);
    idle_cycles(2);

    // Reset during LOAD cycle 7 aborts the operation
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_ser = 1'b1;
      b_ser = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    a_ser = 1'b0;
    b_ser = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t4_busy", {31'b0, busy}, 32'd0);
    check("t4_valid", {31'b0, out_valid}, 32'd0);
    check("t4_done", {31'b0, done}, 32'd0);
    check("t4_lanes", {30'b0, out_hi, out_lo}, 32'd0);
    check("t4_result", result, 32'd0);
    count_done(60, c);
    check("t4_no_done", c, 32'd0);
    start_load(16'd7, 16'd7, 1'b0);
    collect("t4", 0, 0);
    check("t4_const", result, 32'h0000_0031);
    idle_cycles(2);

    // start_i pulses during COMP and SHIFT are ignored
    start_load(16'd100, 16'hFFFD, 1'b0);
    collect("t5", 20, 40);
    count_done(60, c);
    check("t5_single_done", c, 32'd0);
    check("t5_result_held", result, 32'hFFFF_FED4);
    check("t5_busy_after", {31'b0, busy}, 32'd0);

    // Back-to-back: start asserted in the done_o cycle
    start_load(16'h0102, 16'h0304, 1'b0);
    collect("t6a", 0, 0);
    start_load(16'hFFFF, 16'hFFFF, 1'b0);
    collect("t6b", 0, 0);
    check("t6b_const", result, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
